// File: rtl/mmio_led_responder.sv
// LED-window MMIO responder: register map, global PWM dimmer and per-LED blink engine.
// Define MMIO_LED_BLINK_EN to build the prescaler, BLINK_MASK, BLINK_PERIOD and STATUS.bit0.
module mmio_led_responder #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  input  logic [3:0]          addr,
  input  logic [15:0]         wdata,
  output logic [15:0]         rdata,
  output logic [NUM_LEDS-1:0] leds
);

  localparam logic [3:0] A_LED_OUT  = 4'h0;
  localparam logic [3:0] A_PWM_DUTY = 4'h1;

  if (NUM_LEDS < 1 || NUM_LEDS > 16 || PWM_BITS < 1 || PWM_BITS > 16 || PRESCALE < 1)
  begin : g_bad_params
    $error("mmio_led_responder: parameter out of range");
  end

  logic [NUM_LEDS-1:0] r_led_out;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_pcnt;
  logic                w_pwm_on;
  logic [NUM_LEDS-1:0] w_blank;
  logic [15:0]         w_rd;

  // All-ones duty must be solid on, so it bypasses the compare.
  assign w_pwm_on = (&r_duty) | (r_pcnt < r_duty);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_out <= '0;
      r_duty    <= '1;
      r_pcnt    <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
      if (sel && addr == A_LED_OUT)  r_led_out <= wdata[NUM_LEDS-1:0];
      if (sel && addr == A_PWM_DUTY) r_duty    <= wdata[PWM_BITS-1:0];
    end
  end

`ifdef MMIO_LED_BLINK_EN
  localparam logic [3:0] A_BLINK_MASK   = 4'h2;
  localparam logic [3:0] A_BLINK_PERIOD = 4'h3;
  localparam logic [3:0] A_STATUS       = 4'h4;
  localparam int         PRE_W          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    r_pre;
  logic [NUM_LEDS-1:0] r_mask;
  logic [15:0]         r_period;
  logic [15:0]         r_bcnt;
  logic                r_phase;
  logic                w_tick;
  logic                w_period_wr;

  assign w_tick      = (r_pre == PRE_MAX);
  assign w_period_wr = sel && (addr == A_BLINK_PERIOD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre    <= '0;
      r_mask   <= '0;
      r_period <= '0;
      r_bcnt   <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (sel && addr == A_BLINK_MASK) r_mask <= wdata[NUM_LEDS-1:0];
      // A period write restarts the half-period count and takes priority over a tick.
      if (w_period_wr) begin
        r_period <= wdata;
        r_bcnt   <= '0;
        if (wdata == 16'd0) r_phase <= 1'b0;
      end else if (w_tick && r_period != 16'd0) begin
        if (r_bcnt == r_period - 16'd1) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + 16'd1;
        end
      end
    end
  end

  assign w_blank = r_mask & {NUM_LEDS{r_phase}};
`else
  logic w_unused;
  assign w_unused = ^wdata;
  assign w_blank  = '0;
`endif

  always_comb begin
    w_rd = 16'h0000;
    case (addr)
      A_LED_OUT:      w_rd[NUM_LEDS-1:0] = r_led_out;
      A_PWM_DUTY:     w_rd[PWM_BITS-1:0] = r_duty;
`ifdef MMIO_LED_BLINK_EN
      A_BLINK_MASK:   w_rd[NUM_LEDS-1:0] = r_mask;
      A_BLINK_PERIOD: w_rd = r_period;
      A_STATUS:       w_rd[0] = r_phase;
`endif
      default:        w_rd = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 16'h0000;
      leds  <= '0;
    end else begin
      rdata <= w_rd;
      leds  <= r_led_out & {NUM_LEDS{w_pwm_on}} & ~w_blank;
    end
  end

endmodule
